pc_sequencer: RTL

Multi-cycle fetch and next-PC sequencer for the MIPS-subset core. It sits upstream of the opcode decoder: it fetches the instruction word, holds it in an instruction register and presents it to the decoder and datapath. It then consumes the decoder's `branch`, `bn`, `jump` and `brjmpcont` outputs, plus the ALU flags, to choose the next PC. Memory-indirect control transfers (taken `bmz`, and `jrsal`) wait on a data-memory handshake before the PC is updated.

---
 rtl/pc_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Multi-cycle fetch and next-PC sequencer for the MIPS-subset core. It fetches
// an instruction word into the instruction register, presents it for one
// execute cycle, and then picks the next PC. The choice uses the decoder's
// branch/bn/jump/brjmpcont outputs and the ALU flags. Memory-indirect
// transfers (taken bmz, jrsal) wait for the data-memory target before the PC
// is updated.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   imem_req/addr/ack/rdata   instruction fetch handshake (addr == pc)
//   instr                 instruction register (opcode in [31:26])
//   exec                  one-cycle pulse: instruction in instr executes now
//   branch, bn, jump, brjmpcont   decoder control inputs
//   zero, neg             ALU flags of the executing instruction
//   dmem_req/ack/rdata    indirect-target read handshake
//   link                  pc + 4 (combinational), link-store write data
//   pc                    current PC
//   retired               count of completed instructions (wraps)
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        exec,
    input  logic        branch,
    input  logic        bn,
    input  logic        jump,
    input  logic [2:0]  brjmpcont,
    input  logic        zero,
    input  logic        neg,
    output logic        dmem_req,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] link,
    output logic [31:0] pc,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_EXEC    = 2'b01,
        ST_MEMWAIT = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] instr_r;
    logic [31:0] instr_nxt_s;
    logic [31:0] retired_r;
    logic [31:0] retired_nxt_s;
    logic        exec_r;
    logic        dmem_req_r;

    logic [31:0] link_s;
    logic [31:0] br_off_s;
    logic [31:0] br_tgt_s;
    logic [31:0] jmp_tgt_s;
    logic        is_jrsal_s;
    logic        is_bmz_s;
    logic        indirect_s;

    // Target arithmetic; all adds wrap modulo 2^32.
    assign link_s     = pc_r + 32'd4;
    assign br_off_s   = {{14{instr_r[15]}}, instr_r[15:0], 2'b00};
    assign br_tgt_s   = link_s + br_off_s;
    assign jmp_tgt_s  = {link_s[31:28], instr_r[25:0], 2'b00};
    // Unlisted brjmpcont encodings fall through as "no special control".
    assign is_jrsal_s = (brjmpcont == 3'b100);
    assign is_bmz_s   = (brjmpcont == 3'b001);
    assign indirect_s = is_jrsal_s || (is_bmz_s && zero);

    // State, PC, instruction register, retire counter and phase flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_FETCH;
            pc_r       <= RESET_PC;
            instr_r    <= 32'h0000_0000;
            retired_r  <= 32'h0000_0000;
            exec_r     <= 1'b0;
            dmem_req_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            instr_r    <= instr_nxt_s;
            retired_r  <= retired_nxt_s;
            exec_r     <= (state_nxt_s == ST_EXEC);
            dmem_req_r <= (state_nxt_s == ST_MEMWAIT);
        end
    end

    // Next-state and next-PC selection; in EXEC the first matching rule wins.
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        instr_nxt_s   = instr_r;
        retired_nxt_s = retired_r;
        case (state_r)
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_nxt_s = imem_rdata;
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (indirect_s) begin
                    state_nxt_s = ST_MEMWAIT;
                end else begin
                    state_nxt_s   = ST_FETCH;
                    retired_nxt_s = retired_r + 32'd1;
                    // A not-taken bmz still outranks jump and branch.
                    if (is_bmz_s) begin
                        pc_nxt_s = link_s;
                    end else if (jump) begin
                        pc_nxt_s = jmp_tgt_s;
                    end else if ((branch && zero) || (bn && neg)) begin
                        pc_nxt_s = br_tgt_s;
                    end else begin
                        pc_nxt_s = link_s;
                    end
                end
            end
            ST_MEMWAIT: begin
                if (dmem_ack) begin
                    // Force word alignment of the memory-supplied target.
                    pc_nxt_s      = dmem_rdata & 32'hFFFF_FFFC;
                    retired_nxt_s = retired_r + 32'd1;
                    state_nxt_s   = ST_FETCH;
                end else begin
                    state_nxt_s = ST_MEMWAIT;
                end
            end
            default: begin
                state_nxt_s = ST_FETCH;
            end
        endcase
    end

    // The fetch request is the FETCH state itself, suppressed while reset is held.
    assign imem_req  = (state_r == ST_FETCH) && !reset;
    assign imem_addr = pc_r;
    assign instr     = instr_r;
    assign exec      = exec_r;
    assign dmem_req  = dmem_req_r;
    assign link      = link_s;
    assign pc        = pc_r;
    assign retired   = retired_r;

endmodule
